pipe_mdu: RTL and testbench



---
 rtl/mdu_pkg.sv | 42 ++++
 rtl/pipe_mdu_if.sv | 33 +++
 rtl/mdu_seq_core.sv | 69 ++++++
 rtl/pipe_mdu.sv | 135 +++++++++++++
 tb/tb_pipe_mdu.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types, constants and op-decode helpers for the multiply/divide unit
//
// Contents:
//   mdu_op_t     4-bit operation code (codes 10..15 decode as NOP)
//   mdu_state_t  controller states IDLE / ITER / FIX / MUL
//   ITER_STEPS   number of shift-add / shift-subtract steps per iterative op
//   is_long_op   op stalls the pipeline until done
//   is_signed_op op treats its operands as two's complement
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MUL   = 4'd5,
        OP_MFHI  = 4'd6,
        OP_MFLO  = 4'd7,
        OP_MTHI  = 4'd8,
        OP_MTLO  = 4'd9
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        MUL  = 2'd3
    } mdu_state_t;

    localparam int ITER_STEPS = 32;

    function automatic logic is_long_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) ||
               (op == OP_DIVU) || (op == OP_MUL);
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/pipe_mdu_if.sv
// rtl/pipe_mdu_if.sv - EXE-stage to multiply/divide unit interface
//
// Signals:
//   mdu_en   EXE holds an MDU instruction this cycle        (master -> slave)
//   mdu_op   operation code, held while stall is high        (master -> slave)
//   a, b     forwarded rs / rt values                        (master -> slave)
//   stall    freeze IF/ID/EXE, bubble into MEM               (slave -> master)
//   done     one-cycle pulse, long op finished               (slave -> master)
//   mdu_out  result to the write-back select                 (slave -> master)
//   hi, lo   HI / LO register contents                       (slave -> master)
interface pipe_mdu_if;

    logic        mdu_en;
    logic [3:0]  mdu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall;
    logic        done;
    logic [31:0] mdu_out;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output mdu_en, mdu_op, a, b,
        input  stall, done, mdu_out, hi, lo
    );

    modport slave (
        input  mdu_en, mdu_op, a, b,
        output stall, done, mdu_out, hi, lo
    );

endinterface

// File: rtl/mdu_seq_core.sv
// rtl/mdu_seq_core.sv - unsigned 32-step shift-add multiply / shift-subtract divide datapath
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       load operands, clear step counter
//   div         at start: 1 = divide op_a / op_b, 0 = multiply op_a * op_b
//   op_a, op_b  operand magnitudes
//   step        perform one iteration this cycle
//   last        the step being taken now is the final one
//   result      divide: {remainder, quotient}; multiply: 64-bit product
module mdu_seq_core
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        div,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        step,
    output logic        last,
    output logic [63:0] result
);

    logic [63:0] acc;
    logic [31:0] m;
    logic [4:0]  cnt;
    logic        mode_div;
    logic [32:0] div_part;
    logic        div_fit;
    logic [31:0] div_rem;
    logic [32:0] mul_sum;

    // Divide keeps the partial remainder in acc[63:32] and shifts quotient
    // bits into acc[0]. The shifted remainder is below 2*m, so after a
    // successful subtract it fits back into 32 bits.
    // Multiply keeps the multiplier in acc[31:0] and shifts right, adding
    // the multiplicand into the top half whenever the outgoing bit is set.
    always_comb begin
        div_part = acc[63:31];
        div_fit  = div_part >= {1'b0, m};
        div_rem  = div_part[31:0] - m;
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, m} : 33'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            m        <= '0;
            cnt      <= '0;
            mode_div <= 1'b0;
        end else if (start) begin
            acc      <= div ? {32'd0, op_a} : {32'd0, op_b};
            m        <= div ? op_b : op_a;
            cnt      <= '0;
            mode_div <= div;
        end else if (step) begin
            if (mode_div)
                acc <= div_fit ? {div_rem, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
            else
                acc <= {mul_sum, acc[31:1]};
            cnt <= cnt + 5'd1;
        end
    end

    assign last   = cnt == 5'(ITER_STEPS - 1);
    assign result = acc;

endmodule

// File: rtl/pipe_mdu.sv
// rtl/pipe_mdu.sv - EXE-stage multiply/divide unit owning HI/LO, with pipeline stall
//
// Ports:
//   clk    pipeline clock
//   rst_n  asynchronous active-low reset
//   bus    pipe_mdu_if.slave: mdu_en/mdu_op/a/b in; stall/done/mdu_out/hi/lo out
//
// Build option MDU_MULT_ITER_EN: when defined, multiplies run on the shared
// 32-step iterative datapath; otherwise a registered single-cycle multiplier
// is used. Divides are iterative in both builds.
module pipe_mdu
    import mdu_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    pipe_mdu_if.slave bus
);

    mdu_state_t  state;
    logic [31:0] hi_r, lo_r;
    logic [31:0] a_raw, b_raw;
    logic        done_r;
    logic        neg_a, neg_b, op_div;

    logic        op_is_div, signed_op, accept, start_iter, core_last;
    logic [31:0] mag_a, mag_b, q_fix, r_fix;
    logic [63:0] core_res, p_fix;

    always_comb begin
        op_is_div = (bus.mdu_op == OP_DIV) || (bus.mdu_op == OP_DIVU);
        signed_op = is_signed_op(bus.mdu_op);
        // done_r blocks a relaunch of the held instruction in its release cycle
        accept    = bus.mdu_en && is_long_op(bus.mdu_op) && (state == IDLE) && !done_r;
        mag_a     = (signed_op && bus.a[31]) ? -bus.a : bus.a;
        mag_b     = (signed_op && bus.b[31]) ? -bus.b : bus.b;
`ifdef MDU_MULT_ITER_EN
        start_iter = accept;
`else
        start_iter = accept && op_is_div;
`endif
    end

    mdu_seq_core u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_iter),
        .div    (op_is_div),
        .op_a   (mag_a),
        .op_b   (mag_b),
        .step   (state == ITER),
        .last   (core_last),
        .result (core_res)
    );

    // neg_a/neg_b are only set for signed ops, so unsigned ops pass through.
    // Signed 0x80000000 / -1 falls out naturally: magnitude quotient
    // 0x80000000 negates to itself and the remainder is zero.
    always_comb begin
        q_fix = (neg_a ^ neg_b) ? -core_res[31:0] : core_res[31:0];
        r_fix = neg_a ? -core_res[63:32] : core_res[63:32];
        p_fix = (neg_a ^ neg_b) ? -core_res : core_res;
    end

`ifndef MDU_MULT_ITER_EN
    logic [63:0] mul_prod;
    // neg_x doubles as the sign-extension bit: zero for unsigned ops
    assign mul_prod = {{32{neg_a}}, a_raw} * {{32{neg_b}}, b_raw};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            hi_r   <= '0;
            lo_r   <= '0;
            a_raw  <= '0;
            b_raw  <= '0;
            done_r <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            op_div <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_raw  <= bus.a;
                        b_raw  <= bus.b;
                        neg_a  <= signed_op && bus.a[31];
                        neg_b  <= signed_op && bus.b[31];
                        op_div <= op_is_div;
`ifdef MDU_MULT_ITER_EN
                        state  <= ITER;
`else
                        state  <= op_is_div ? ITER : MUL;
`endif
                    end else if (bus.mdu_en) begin
                        if (bus.mdu_op == OP_MTHI) hi_r <= bus.a;
                        if (bus.mdu_op == OP_MTLO) lo_r <= bus.a;
                    end
                end
                ITER: begin
                    if (core_last) state <= FIX;
                end
                FIX: begin
                    if (op_div && (b_raw == 32'd0)) begin
                        lo_r <= 32'hFFFF_FFFF;
                        hi_r <= a_raw;
                    end else if (op_div) begin
                        lo_r <= q_fix;
                        hi_r <= r_fix;
                    end else begin
                        {hi_r, lo_r} <= p_fix;
                    end
                    done_r <= 1'b1;
                    state  <= IDLE;
                end
`ifndef MDU_MULT_ITER_EN
                MUL: begin
                    {hi_r, lo_r} <= mul_prod;
                    done_r <= 1'b1;
                    state  <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.stall   = (state != IDLE) || accept;
    assign bus.done    = done_r;
    assign bus.hi      = hi_r;
    assign bus.lo      = lo_r;
    assign bus.mdu_out = (bus.mdu_op == OP_MFHI) ? hi_r : lo_r;

endmodule

// File: tb/tb_pipe_mdu.sv
// tb/tb_pipe_mdu.sv - scoreboard testbench for pipe_mdu with arithmetic reference model
module tb_pipe_mdu;
    import mdu_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          n_tests = 0;
    int          n_fail = 0;
    int          stall_cycles = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] mdl_hi = 32'd0;
    logic [31:0] mdl_lo = 32'd0;

    pipe_mdu_if bus();

    pipe_mdu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural rules.
    function automatic void ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] h, output logic [31:0] l, output int lat);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        lat = 34;
        h = mdl_hi;
        l = mdl_lo;
        case (op)
            OP_MULT, OP_MUL: begin
                sp = sa * sb;
                {h, l} = sp;
`ifndef MDU_MULT_ITER_EN
                lat = 2;
`endif
            end
            OP_MULTU: begin
                up = ua * ub;
                {h, l} = up;
`ifndef MDU_MULT_ITER_EN
                lat = 2;
`endif
            end
            OP_DIV: begin
                if (b == 32'd0) begin
                    l = 32'hFFFF_FFFF;
                    h = a;
                end else begin
                    l = 32'(sa / sb);
                    h = 32'(sa % sb);
                end
            end
            OP_DIVU: begin
                if (b == 32'd0) begin
                    l = 32'hFFFF_FFFF;
                    h = a;
                end else begin
                    l = 32'(ua / ub);
                    h = 32'(ua % ub);
                end
            end
            default: ;
        endcase
    endfunction

    // Monitor: counts stalled cycles and checks HI/LO/mdu_out/latency on done.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_cycles = 0;
        end else begin
            if (bus.stall) stall_cycles++;
            if (bus.done) begin
                check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("done_hi", bus.hi, mon_e.hi);
                    check("done_lo", bus.lo, mon_e.lo);
                    check("done_mdu_out", bus.mdu_out, mon_e.lo);
                    check("stall_len", 32'(stall_cycles), 32'(mon_e.lat));
                end
                stall_cycles = 0;
            end
        end
    end

    // Called just after a rising edge; returns just after a rising edge.
    task automatic issue_long(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   k;
        ref_model(op, a, b, e.hi, e.lo, e.lat);
        exp_q.push_back(e);
        bus.mdu_en = 1'b1;
        bus.mdu_op = op;
        bus.a      = a;
        bus.b      = b;
        #1;
        check("stall_accept", 32'(bus.stall), 32'd1);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!bus.done && k < 100);
        check("done_seen", 32'(bus.done), 32'd1);
        check("stall_release", 32'(bus.stall), 32'd0);
        @(posedge clk);
        #1;
        bus.mdu_en = 1'b0;
        bus.mdu_op = OP_NOP;
        #1;
        check("no_relaunch", 32'(bus.stall), 32'd0);
        mdl_hi = e.hi;
        mdl_lo = e.lo;
    endtask

    task automatic issue_short(input logic [3:0] op, input logic [31:0] a);
        bus.mdu_en = 1'b1;
        bus.mdu_op = op;
        bus.a      = a;
        bus.b      = $urandom;
        #1;
        check("short_stall", 32'(bus.stall), 32'd0);
        check("short_mdu_out", bus.mdu_out, (op == OP_MFHI) ? mdl_hi : mdl_lo);
        @(posedge clk);
        #1;
        if (op == OP_MTHI) mdl_hi = a;
        if (op == OP_MTLO) mdl_lo = a;
        bus.mdu_en = 1'b0;
        bus.mdu_op = OP_NOP;
        check("short_hi", bus.hi, mdl_hi);
        check("short_lo", bus.lo, mdl_lo);
    endtask

    logic [3:0] long_ops[5] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MUL};
    logic [3:0] short_ops[6] = '{OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO, 4'd10, 4'd15};

    initial begin
        logic [31:0] ra, rb;
        rst_n      = 1'b0;
        bus.mdu_en = 1'b0;
        bus.mdu_op = OP_NOP;
        bus.a      = '0;
        bus.b      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue_long(OP_DIV,   32'hFFFF_FFF9, 32'd2);
        issue_long(OP_DIVU,  32'd7,         32'd0);
        issue_long(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        issue_long(OP_MULT,  32'hFFFF_FFFE, 32'd3);
        issue_long(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
        issue_long(OP_MUL,   32'd5,         32'd6);
        issue_short(OP_MTHI, 32'h0000_1234);
        issue_short(OP_MFHI, 32'd0);
        issue_short(4'd12,   32'hDEAD_BEEF);
        issue_short(OP_MFLO, 32'd0);
        issue_long(OP_DIV,   32'd9,         32'hFFFF_FFFE);

        // Reset in cycle c+10 of a divide
        bus.mdu_en = 1'b1;
        bus.mdu_op = OP_DIV;
        bus.a      = 32'd12345;
        bus.b      = 32'd17;
        repeat (10) @(posedge clk);
        #1;
        rst_n      = 1'b0;
        bus.mdu_en = 1'b0;
        bus.mdu_op = OP_NOP;
        #1;
        check("midrst_hi", bus.hi, 32'd0);
        check("midrst_lo", bus.lo, 32'd0);
        check("midrst_stall", 32'(bus.stall), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        mdl_hi = 32'd0;
        mdl_lo = 32'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue_long(OP_DIVU, 32'd100, 32'd7);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 7))
                0: begin ra = $urandom; rb = 32'd0; end
                1: begin ra = $urandom_range(0, 200); rb = $urandom_range(1, 13); end
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: begin ra = -($urandom_range(1, 1000)); rb = $urandom_range(1, 50); end
                default: begin ra = $urandom; rb = $urandom; end
            endcase
            issue_long(long_ops[$urandom_range(0, 4)], ra, rb);
            if ($urandom_range(0, 1) == 1)
                issue_short(short_ops[$urandom_range(0, 5)], $urandom);
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
